// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative multiply/divide sequencer beside the EX stage.
// Runs MULT/MULTU/DIV/DIVU on the forwarded EX operands (one operation in
// flight) and owns the architectural HI/LO registers.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_start, i_op           EX holds a mul/div (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   i_operand_a/b           forwarded rs / rt values
//   i_flush                 abort the in-flight operation (wins over commit)
//   i_mf_req                EX holds MFHI/MFLO
//   o_busy                  sequencer not idle
//   o_stall                 combinational: o_busy & (i_mf_req | i_start)
//   o_done                  one-cycle pulse when HI/LO are committed
//   o_div_by_zero           sticky; set by a divide by zero, cleared on next accept
//   o_hi, o_lo              HI / LO registers
//
// Build option: define EX_MULDIV_EARLY_OUT_EN to skip iterations that cannot
// change the result (zero multiplier tail, leading zeros of the dividend).
module ex_muldiv_ctrl #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [1:0]            i_op,
   input  logic [DATA_WIDTH-1:0] i_operand_a,
   input  logic [DATA_WIDTH-1:0] i_operand_b,
   input  logic                  i_flush,
   input  logic                  i_mf_req,
   output logic                  o_busy,
   output logic                  o_stall,
   output logic                  o_done,
   output logic                  o_div_by_zero,
   output logic [DATA_WIDTH-1:0] o_hi,
   output logic [DATA_WIDTH-1:0] o_lo
);

   localparam int unsigned W     = DATA_WIDTH;
   localparam int unsigned W2    = 2 * DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      ADJUST = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W2-1:0]    acc_q, acc_d;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
   logic [W-1:0]     opnd_q, opnd_d;    // multiplicand or divisor magnitude
   logic             is_div_q, is_div_d;
   logic             neg_lo_q, neg_lo_d; // negate product / quotient
   logic             neg_hi_q, neg_hi_d; // negate remainder
   logic             dbz_q, dbz_d;
   logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic             done_q, done_d;
   logic             dbz_flag_q, dbz_flag_d;
   logic             busy_q, busy_d;

   // Operand magnitudes; unsigned ops pass operands through untouched
   logic         is_signed, a_neg, b_neg;
   logic [W-1:0] a_mag, b_mag;

   assign is_signed = ~i_op[0];
   assign a_neg     = is_signed & i_operand_a[W-1];
   assign b_neg     = is_signed & i_operand_b[W-1];
   assign a_mag     = a_neg ? W'(-i_operand_a) : i_operand_a;
   assign b_mag     = b_neg ? W'(-i_operand_b) : i_operand_b;

   // Restoring divide step; the borrow of the trial subtraction is the inverted quotient bit
   logic [W:0]    rem_sh, rem_diff;
   logic          q_bit;
   logic [W2-1:0] div_next;

   assign rem_sh   = {acc_q[W2-1:W], acc_q[W-1]};
   assign rem_diff = rem_sh - {1'b0, opnd_q};
   assign q_bit    = ~rem_diff[W];
   assign div_next = {(q_bit ? rem_diff[W-1:0] : rem_sh[W-1:0]), acc_q[W-2:0], q_bit};

   // Shift-add multiply step, multiplier consumed LSB first
   logic [W:0]    mul_sum;
   logic [W2-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[W-1:1]};

   // Sign fix-up applied in ADJUST
   logic [W2-1:0] prod_fix;
   logic [W-1:0]  quo_fix, rem_fix;

   assign prod_fix = neg_lo_q ? W2'(-acc_q) : acc_q;
   assign quo_fix  = neg_lo_q ? W'(-acc_q[W-1:0]) : acc_q[W-1:0];
   assign rem_fix  = neg_hi_q ? W'(-acc_q[W2-1:W]) : acc_q[W2-1:W];

`ifdef EX_MULDIV_EARLY_OUT_EN
   // Number of significant bits in v (0 for v == 0)
   function automatic logic [CNT_W-1:0] sig_bits(input logic [W-1:0] v);
      sig_bits = '0;
      for (int i = 0; i < int'(W); i++) begin
         if (v[i]) sig_bits = CNT_W'(i + 1);
      end
   endfunction

   logic [CNT_W-1:0] a_sig;
   logic [W-1:0]     rest_mask;
   logic             mul_rest_zero;

   assign a_sig         = sig_bits(a_mag);
   // Low cnt_q bits of the accumulator are the multiplier bits not yet consumed
   assign rest_mask     = ~({W{1'b1}} << cnt_q);
   assign mul_rest_zero = ((acc_q[W-1:0] & rest_mask) == '0);
`endif

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      is_div_d   = is_div_q;
      neg_lo_d   = neg_lo_q;
      neg_hi_d   = neg_hi_q;
      dbz_d      = dbz_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      dbz_flag_d = dbz_flag_q;

      case (state_q)
         IDLE: begin
            if (i_start && !i_flush) begin
               dbz_flag_d = 1'b0;
               is_div_d   = i_op[1];
               neg_lo_d   = a_neg ^ b_neg;
               neg_hi_d   = i_op[1] & a_neg;
               dbz_d      = 1'b0;
               cnt_d      = CNT_W'(W);
               state_d    = CALC;
               if (!i_op[1]) begin
                  opnd_d = a_mag;
                  acc_d  = {{W{1'b0}}, b_mag};
               end else if (i_operand_b == '0) begin
                  // Divide by zero: result is fixed, no iterations needed
                  dbz_d    = 1'b1;
                  neg_lo_d = 1'b0;
                  neg_hi_d = 1'b0;
                  acc_d    = {i_operand_a, {W{1'b1}}};
                  cnt_d    = '0;
                  state_d  = ADJUST;
               end else begin
                  opnd_d = b_mag;
`ifdef EX_MULDIV_EARLY_OUT_EN
                  // Leading zero dividend bits only produce zero quotient bits
                  acc_d = {{W{1'b0}}, W'(a_mag << (W - a_sig))};
                  cnt_d = a_sig;
                  if (a_sig == '0) state_d = ADJUST;
`else
                  acc_d = {{W{1'b0}}, a_mag};
`endif
               end
            end
         end

         CALC: begin
            if (i_flush) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (is_div_q) begin
                  acc_d = div_next;
               end else begin
                  acc_d = mul_next;
`ifdef EX_MULDIV_EARLY_OUT_EN
                  // Remaining steps would only shift; align the product in one go
                  if (mul_rest_zero) begin
                     acc_d = acc_q >> cnt_q;
                     cnt_d = '0;
                  end
`endif
               end
               if (cnt_d == '0) state_d = ADJUST;
            end
         end

         ADJUST: begin
            state_d = IDLE;
            if (!i_flush) begin
               done_d = 1'b1;
               if (is_div_q) begin
                  hi_d       = rem_fix;
                  lo_d       = quo_fix;
                  dbz_flag_d = dbz_q;
               end else begin
                  hi_d = prod_fix[W2-1:W];
                  lo_d = prod_fix[W-1:0];
               end
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and working registers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         is_div_q   <= 1'b0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         dbz_q      <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         dbz_flag_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         is_div_q   <= is_div_d;
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
         dbz_q      <= dbz_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         dbz_flag_q <= dbz_flag_d;
         busy_q     <= busy_d;
      end
   end

   assign o_busy        = busy_q;
   assign o_stall       = busy_q & (i_mf_req | i_start);
   assign o_done        = done_q;
   assign o_div_by_zero = dbz_flag_q;
   assign o_hi          = hi_q;
   assign o_lo          = lo_q;

endmodule
